// File: rtl/sd_spi_responder.sv
// SPI-mode SD card responder: oversamples the initiator's SPI pins on clk, decodes
// init and single-block commands, and serves 512-byte blocks from an external store.
`timescale 1ns/1ps

module sd_spi_responder #(
    parameter int IDLE_POLLS       = 2,
    parameter int NCR_BYTES        = 1,
    parameter int WRITE_BUSY_BYTES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_clk,
    input  logic        cs,
    input  logic        mosi,
    output logic        miso,
    output logic [31:0] blk_addr,
    output logic [8:0]  byte_idx,
    input  logic [7:0]  rd_data,
    output logic [7:0]  wr_data,
    output logic        wr_en,
    output logic [5:0]  cmd_index,
    output logic        cmd_strobe,
    output logic        card_ready
);

    localparam logic [3:0] S_CMD      = 4'd0;
    localparam logic [3:0] S_NCR      = 4'd1;
    localparam logic [3:0] S_R1       = 4'd2;
    localparam logic [3:0] S_EXTRA    = 4'd3;
    localparam logic [3:0] S_RD_TOKEN = 4'd4;
    localparam logic [3:0] S_RD_DATA  = 4'd5;
    localparam logic [3:0] S_RD_CRC   = 4'd6;
    localparam logic [3:0] S_WR_TOKEN = 4'd7;
    localparam logic [3:0] S_WR_DATA  = 4'd8;
    localparam logic [3:0] S_WR_CRC   = 4'd9;
    localparam logic [3:0] S_WR_RESP  = 4'd10;
    localparam logic [3:0] S_WR_BUSY  = 4'd11;

    localparam logic [1:0] P_NONE  = 2'd0;
    localparam logic [1:0] P_EXTRA = 2'd1;
    localparam logic [1:0] P_READ  = 2'd2;
    localparam logic [1:0] P_WRITE = 2'd3;

    localparam logic [7:0] LP_POLLS = 8'(IDLE_POLLS);
    localparam logic [9:0] LP_NCR   = 10'(NCR_BYTES);
    localparam logic [9:0] LP_BUSY  = 10'(WRITE_BUSY_BYTES);

    logic [1:0]  r_sclk_sync;
    logic [1:0]  r_cs_sync;
    logic [1:0]  r_mosi_sync;
    logic        r_sclk_prev;

    logic [3:0]  r_state;
    logic [2:0]  r_bit_cnt;
    logic [9:0]  r_cnt;
    logic [6:0]  r_rx_sr;
    logic [7:0]  r_tx;
    logic [5:0]  r_cmd_idx;
    logic [31:0] r_arg;
    logic [7:0]  r_r1;
    logic [31:0] r_extra;
    logic [1:0]  r_phase;
    logic        r_idle;
    logic        r_app_cmd;
    logic [7:0]  r_acmd_cnt;
    logic        r_ready;
    logic [31:0] r_blk_addr;
    logic [8:0]  r_byte_idx;
    logic [7:0]  r_wr_data;
    logic        r_wr_en;
    logic [5:0]  r_cmd_index;
    logic        r_cmd_strobe;

    logic        w_sclk;
    logic        w_rise;
    logic        w_fall;
    logic        w_cs_n;
    logic        w_mosi;
    logic [7:0]  w_rx_byte;

    logic        w_idle_next;
    logic [7:0]  w_acmd_next;
    logic [7:0]  w_acmd_inc;
    logic        w_illegal;
    logic [1:0]  w_phase;
    logic [31:0] w_extra;
    logic [7:0]  w_r1;

    assign w_sclk    = r_sclk_sync[1];
    assign w_rise    = w_sclk & ~r_sclk_prev;
    assign w_fall    = ~w_sclk & r_sclk_prev;
    assign w_cs_n    = r_cs_sync[1];
    assign w_mosi    = r_mosi_sync[1];
    assign w_rx_byte = {r_rx_sr, w_mosi};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= 2'b00;
            r_cs_sync   <= 2'b11;
            r_mosi_sync <= 2'b11;
            r_sclk_prev <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], spi_clk};
            r_cs_sync   <= {r_cs_sync[0], cs};
            r_mosi_sync <= {r_mosi_sync[0], mosi};
            r_sclk_prev <= w_sclk;
        end
    end

    // Effect of the just-collected command frame, evaluated when its CRC byte lands
    always_comb begin
        w_idle_next = r_idle;
        w_acmd_next = r_acmd_cnt;
        w_acmd_inc  = (r_acmd_cnt == 8'hFF) ? r_acmd_cnt : r_acmd_cnt + 8'd1;
        w_illegal   = 1'b0;
        w_phase     = P_NONE;
        w_extra     = 32'hFFFF_FFFF;
        case (r_cmd_idx)
            6'd0: begin
                w_idle_next = 1'b1;
                w_acmd_next = 8'd0;
            end
            6'd8: begin
                w_phase = P_EXTRA;
                w_extra = {24'h000001, r_arg[7:0]};
            end
            6'd55: begin
                w_phase = P_NONE;
            end
            6'd41: begin
                if (r_app_cmd) begin
                    w_acmd_next = w_acmd_inc;
                    if (w_acmd_inc >= LP_POLLS) begin
                        w_idle_next = 1'b0;
                    end
                end else begin
                    w_illegal = 1'b1;
                end
            end
            6'd58: begin
                w_phase = P_EXTRA;
                w_extra = 32'hC0FF_8000;
            end
            6'd17: begin
                if (!r_idle) w_phase = P_READ;
                else         w_illegal = 1'b1;
            end
            6'd24: begin
                if (!r_idle) w_phase = P_WRITE;
                else         w_illegal = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
        w_r1 = {5'b00000, w_illegal, 1'b0, w_idle_next};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_CMD;
            r_bit_cnt    <= 3'd0;
            r_cnt        <= 10'd0;
            r_tx         <= 8'hFF;
            r_phase      <= P_NONE;
            r_idle       <= 1'b1;
            r_app_cmd    <= 1'b0;
            r_acmd_cnt   <= 8'd0;
            r_ready      <= 1'b0;
            r_blk_addr   <= 32'd0;
            r_byte_idx   <= 9'd0;
            r_wr_data    <= 8'd0;
            r_wr_en      <= 1'b0;
            r_cmd_index  <= 6'd0;
            r_cmd_strobe <= 1'b0;
        end else begin
            r_wr_en      <= 1'b0;
            r_cmd_strobe <= 1'b0;
            // Deselect has priority over a byte completing in the same cycle
            if (w_cs_n) begin
                r_tx      <= 8'hFF;
                r_bit_cnt <= 3'd0;
                r_state   <= S_CMD;
                r_cnt     <= 10'd0;
            end else if (w_rise) begin
                r_rx_sr   <= w_rx_byte[6:0];
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    case (r_state)
                        S_CMD: begin
                            r_tx <= 8'hFF;
                            if (r_cnt == 10'd0) begin
                                if (w_rx_byte[7:6] == 2'b01) begin
                                    r_cmd_idx <= w_rx_byte[5:0];
                                    r_cnt     <= 10'd1;
                                end
                            end else if (r_cnt < 10'd5) begin
                                r_arg <= {r_arg[23:0], w_rx_byte};
                                r_cnt <= r_cnt + 10'd1;
                            end else begin
                                r_cmd_strobe <= 1'b1;
                                r_cmd_index  <= r_cmd_idx;
                                r_app_cmd    <= (r_cmd_idx == 6'd55);
                                r_idle       <= w_idle_next;
                                r_ready      <= ~w_idle_next;
                                r_acmd_cnt   <= w_acmd_next;
                                r_r1         <= w_r1;
                                r_phase      <= w_phase;
                                r_extra      <= w_extra;
                                if (w_phase == P_READ || w_phase == P_WRITE) begin
                                    r_blk_addr <= r_arg;
                                end
                                r_state <= S_NCR;
                                r_cnt   <= 10'd1;
                            end
                        end
                        S_NCR: begin
                            if (r_cnt >= LP_NCR) begin
                                r_tx       <= r_r1;
                                r_byte_idx <= 9'd0;
                                r_state    <= S_R1;
                                r_cnt      <= 10'd0;
                            end else begin
                                r_tx  <= 8'hFF;
                                r_cnt <= r_cnt + 10'd1;
                            end
                        end
                        S_R1: begin
                            case (r_phase)
                                P_EXTRA: begin
                                    r_tx    <= r_extra[31:24];
                                    r_extra <= {r_extra[23:0], 8'hFF};
                                    r_cnt   <= 10'd1;
                                    r_state <= S_EXTRA;
                                end
                                P_READ: begin
                                    r_tx    <= 8'hFE;
                                    r_state <= S_RD_TOKEN;
                                end
                                P_WRITE: begin
                                    r_tx    <= 8'hFF;
                                    r_state <= S_WR_TOKEN;
                                end
                                default: begin
                                    r_tx    <= 8'hFF;
                                    r_cnt   <= 10'd0;
                                    r_state <= S_CMD;
                                end
                            endcase
                        end
                        S_EXTRA: begin
                            if (r_cnt == 10'd4) begin
                                r_tx    <= 8'hFF;
                                r_cnt   <= 10'd0;
                                r_state <= S_CMD;
                            end else begin
                                r_tx    <= r_extra[31:24];
                                r_extra <= {r_extra[23:0], 8'hFF};
                                r_cnt   <= r_cnt + 10'd1;
                            end
                        end
                        S_RD_TOKEN: begin
                            r_tx       <= rd_data;
                            r_byte_idx <= r_byte_idx + 9'd1;
                            r_cnt      <= 10'd1;
                            r_state    <= S_RD_DATA;
                        end
                        S_RD_DATA: begin
                            if (r_cnt == 10'd512) begin
                                r_tx    <= 8'hFF;
                                r_cnt   <= 10'd1;
                                r_state <= S_RD_CRC;
                            end else begin
                                r_tx       <= rd_data;
                                r_byte_idx <= r_byte_idx + 9'd1;
                                r_cnt      <= r_cnt + 10'd1;
                            end
                        end
                        S_RD_CRC: begin
                            r_tx <= 8'hFF;
                            if (r_cnt == 10'd2) begin
                                r_cnt   <= 10'd0;
                                r_state <= S_CMD;
                            end else begin
                                r_cnt <= r_cnt + 10'd1;
                            end
                        end
                        S_WR_TOKEN: begin
                            r_tx <= 8'hFF;
                            if (w_rx_byte == 8'hFE) begin
                                r_cnt   <= 10'd0;
                                r_state <= S_WR_DATA;
                            end
                        end
                        S_WR_DATA: begin
                            r_tx       <= 8'hFF;
                            r_wr_data  <= w_rx_byte;
                            r_byte_idx <= r_cnt[8:0];
                            r_wr_en    <= 1'b1;
                            if (r_cnt == 10'd511) begin
                                r_cnt   <= 10'd0;
                                r_state <= S_WR_CRC;
                            end else begin
                                r_cnt <= r_cnt + 10'd1;
                            end
                        end
                        S_WR_CRC: begin
                            if (r_cnt == 10'd1) begin
                                r_tx    <= 8'h05;
                                r_cnt   <= 10'd0;
                                r_state <= S_WR_RESP;
                            end else begin
                                r_tx  <= 8'hFF;
                                r_cnt <= r_cnt + 10'd1;
                            end
                        end
                        S_WR_RESP: begin
                            r_tx    <= 8'h00;
                            r_cnt   <= 10'd1;
                            r_state <= S_WR_BUSY;
                        end
                        S_WR_BUSY: begin
                            if (r_cnt >= LP_BUSY) begin
                                r_tx    <= 8'hFF;
                                r_cnt   <= 10'd0;
                                r_state <= S_CMD;
                            end else begin
                                r_tx  <= 8'h00;
                                r_cnt <= r_cnt + 10'd1;
                            end
                        end
                        default: begin
                            r_tx    <= 8'hFF;
                            r_cnt   <= 10'd0;
                            r_state <= S_CMD;
                        end
                    endcase
                end
            end else if (w_fall && r_bit_cnt != 3'd0) begin
                r_tx <= {r_tx[6:0], 1'b1};
            end
        end
    end

    assign miso       = r_tx[7];
    assign blk_addr   = r_blk_addr;
    assign byte_idx   = r_byte_idx;
    assign wr_data    = r_wr_data;
    assign wr_en      = r_wr_en;
    assign cmd_index  = r_cmd_index;
    assign cmd_strobe = r_cmd_strobe;
    assign card_ready = r_ready;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: drives an SPI mode-0 initiator through init,
// block read, block write and an aborted read, checking bytes on miso and store strobes.
`timescale 1ns/1ps

module tb_sd_spi_responder;

    localparam int HALF = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_clk;
    logic        cs;
    logic        mosi;
    logic        miso;
    logic [31:0] blk_addr;
    logic [8:0]  byte_idx;
    logic [7:0]  rd_data;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic [5:0]  cmd_index;
    logic        cmd_strobe;
    logic        card_ready;

    logic [7:0]  mem [0:511];

    int          n_vec = 0;
    int          n_bad = 0;
    int          wr_cnt = 0;
    int          wr_idx_bad = 0;
    int          wr_data_bad = 0;
    int          strobe_cnt = 0;
    logic [8:0]  wr_exp_idx = 9'd0;
    logic [8:0]  wr_last_idx = 9'd0;

    sd_spi_responder #(
        .IDLE_POLLS(2),
        .NCR_BYTES(1),
        .WRITE_BUSY_BYTES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .spi_clk(spi_clk),
        .cs(cs),
        .mosi(mosi),
        .miso(miso),
        .blk_addr(blk_addr),
        .byte_idx(byte_idx),
        .rd_data(rd_data),
        .wr_data(wr_data),
        .wr_en(wr_en),
        .cmd_index(cmd_index),
        .cmd_strobe(cmd_strobe),
        .card_ready(card_ready)
    );

    always #5 clk = ~clk;

    assign rd_data = mem[byte_idx];

    always @(negedge clk) begin
        if (wr_en) begin
            if (byte_idx !== wr_exp_idx) wr_idx_bad++;
            if (wr_data !== 8'h5A) wr_data_bad++;
            wr_last_idx = byte_idx;
            wr_exp_idx  = wr_exp_idx + 9'd1;
            wr_cnt++;
        end
        if (cmd_strobe) strobe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
        for (int i = 7; i >= 0; i--) begin
            mosi = b[i];
            #HALF;
            r[i] = miso;
            spi_clk = 1'b1;
            #HALF;
            spi_clk = 1'b0;
        end
    endtask

    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
        logic [7:0] r;
        cs = 1'b0;
        spi_byte({2'b01, idx}, r);
        spi_byte(arg[31:24], r);
        spi_byte(arg[23:16], r);
        spi_byte(arg[15:8], r);
        spi_byte(arg[7:0], r);
        spi_byte(crc, r);
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        logic [7:0] r;
        spi_byte(8'hFF, r);
        check(tag, 32'(r), 32'(exp));
    endtask

    task automatic release_cs();
        mosi = 1'b1;
        cs   = 1'b1;
        #(HALF * 5);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        logic [7:0] d0;
        logic [7:0] d200;
        logic [7:0] d511;
        int         rd_bad;

        for (int i = 0; i < 512; i++) mem[i] = 8'(i);
        rst = 1'b1; cs = 1'b1; spi_clk = 1'b0; mosi = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_miso", 32'(miso), 32'd1);
        check("rst_blk_addr", blk_addr, 32'd0);
        check("rst_byte_idx", 32'(byte_idx), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_cmd_index", 32'(cmd_index), 32'd0);
        check("rst_cmd_strobe", 32'(cmd_strobe), 32'd0);
        check("rst_card_ready", 32'(card_ready), 32'd0);

        send_cmd(6'd0, 32'h0, 8'h95);
        expect_byte("cmd0_ncr", 8'hFF);
        expect_byte("cmd0_r1", 8'h01);
        check("cmd0_ready", 32'(card_ready), 32'd0);
        release_cs();

        send_cmd(6'd8, 32'h0000_01AA, 8'h87);
        expect_byte("cmd8_ncr", 8'hFF);
        expect_byte("cmd8_r1", 8'h01);
        expect_byte("cmd8_b1", 8'h00);
        expect_byte("cmd8_b2", 8'h00);
        expect_byte("cmd8_b3", 8'h01);
        expect_byte("cmd8_b4", 8'hAA);
        check("cmd8_index", 32'(cmd_index), 32'd8);
        release_cs();

        send_cmd(6'd17, 32'h0, 8'hFF);
        expect_byte("early17_ncr", 8'hFF);
        expect_byte("early17_r1", 8'h05);
        expect_byte("early17_notok1", 8'hFF);
        expect_byte("early17_notok2", 8'hFF);
        release_cs();

        send_cmd(6'd55, 32'h0, 8'hFF);
        expect_byte("cmd55a_ncr", 8'hFF);
        expect_byte("cmd55a_r1", 8'h01);
        release_cs();
        send_cmd(6'd41, 32'h4000_0000, 8'hFF);
        expect_byte("acmd41a_ncr", 8'hFF);
        expect_byte("acmd41a_r1", 8'h01);
        check("acmd41a_ready", 32'(card_ready), 32'd0);
        release_cs();
        send_cmd(6'd55, 32'h0, 8'hFF);
        expect_byte("cmd55b_ncr", 8'hFF);
        expect_byte("cmd55b_r1", 8'h01);
        release_cs();
        send_cmd(6'd41, 32'h4000_0000, 8'hFF);
        expect_byte("acmd41b_ncr", 8'hFF);
        expect_byte("acmd41b_r1", 8'h00);
        check("acmd41b_ready", 32'(card_ready), 32'd1);
        check("acmd41b_index", 32'(cmd_index), 32'd41);
        release_cs();

        send_cmd(6'd58, 32'h0, 8'hFF);
        expect_byte("cmd58_ncr", 8'hFF);
        expect_byte("cmd58_r1", 8'h00);
        expect_byte("cmd58_b1", 8'hC0);
        expect_byte("cmd58_b2", 8'hFF);
        expect_byte("cmd58_b3", 8'h80);
        expect_byte("cmd58_b4", 8'h00);
        release_cs();

        send_cmd(6'd17, 32'h0000_0010, 8'hFF);
        expect_byte("rd_ncr", 8'hFF);
        expect_byte("rd_r1", 8'h00);
        expect_byte("rd_token", 8'hFE);
        rd_bad = 0; d0 = 8'h00; d200 = 8'h00; d511 = 8'h00;
        for (int i = 0; i < 512; i++) begin
            spi_byte(8'hFF, r);
            if (r !== 8'(i)) rd_bad++;
            if (i == 0)   d0 = r;
            if (i == 200) d200 = r;
            if (i == 511) d511 = r;
        end
        check("rd_blk_errs", 32'(rd_bad), 32'd0);
        check("rd_byte0", 32'(d0), 32'h00);
        check("rd_byte200", 32'(d200), 32'hC8);
        check("rd_byte511", 32'(d511), 32'hFF);
        expect_byte("rd_crc1", 8'hFF);
        expect_byte("rd_crc2", 8'hFF);
        expect_byte("rd_idle", 8'hFF);
        check("rd_blk_addr", blk_addr, 32'h10);
        check("rd_idx_wrap", 32'(byte_idx), 32'd0);
        check("rd_index", 32'(cmd_index), 32'd17);
        release_cs();

        send_cmd(6'd24, 32'h0000_0005, 8'hFF);
        expect_byte("wr_ncr", 8'hFF);
        expect_byte("wr_r1", 8'h00);
        spi_byte(8'hFE, r);
        for (int i = 0; i < 512; i++) spi_byte(8'h5A, r);
        spi_byte(8'hFF, r);
        spi_byte(8'hFF, r);
        expect_byte("wr_resp", 8'h05);
        expect_byte("wr_busy1", 8'h00);
        expect_byte("wr_busy2", 8'h00);
        expect_byte("wr_idle", 8'hFF);
        check("wr_blk_addr", blk_addr, 32'h5);
        check("wr_pulses", 32'(wr_cnt), 32'd512);
        check("wr_idx_errs", 32'(wr_idx_bad), 32'd0);
        check("wr_data_errs", 32'(wr_data_bad), 32'd0);
        check("wr_last_idx", 32'(wr_last_idx), 32'd511);
        release_cs();

        send_cmd(6'd17, 32'h0000_0020, 8'hFF);
        expect_byte("ab_ncr", 8'hFF);
        expect_byte("ab_r1", 8'h00);
        expect_byte("ab_token", 8'hFE);
        for (int i = 0; i < 100; i++) spi_byte(8'hFF, r);
        release_cs();
        check("ab_miso_idle", 32'(miso), 32'd1);
        check("ab_blk_addr", blk_addr, 32'h20);
        send_cmd(6'd0, 32'h0, 8'h95);
        expect_byte("ab_cmd0_ncr", 8'hFF);
        expect_byte("ab_cmd0_r1", 8'h01);
        expect_byte("ab_cmd0_after", 8'hFF);
        check("ab_wr_pulses", 32'(wr_cnt), 32'd512);
        release_cs();

        check("strobe_count", 32'(strobe_cnt), 32'd12);
        check("final_index", 32'(cmd_index), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
